// File: rtl/jtag_reg_ctrl_if.sv
// JTAG register-access bundle: debug request side, core writeback
// side and register-file debug port grouped into one interface.
interface jtag_reg_ctrl_if;
    logic        req_i;
    logic        req_we_i;
    logic [4:0]  req_addr_i;
    logic [31:0] req_data_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        halt_o;
    logic        ex_we_i;
    logic        regs_we_o;
    logic [4:0]  regs_addr_o;
    logic [31:0] regs_data_o;
    logic [31:0] regs_rdata_i;

    modport slave (
        input  req_i, req_we_i, req_addr_i, req_data_i,
        input  ex_we_i, regs_rdata_i,
        output ack_o, rdata_o, busy_o, halt_o,
        output regs_we_o, regs_addr_o, regs_data_o
    );

    modport master (
        output req_i, req_we_i, req_addr_i, req_data_i,
        output ex_we_i, regs_rdata_i,
        input  ack_o, rdata_o, busy_o, halt_o,
        input  regs_we_o, regs_addr_o, regs_data_o
    );
endinterface

// File: rtl/jtag_reg_ctrl.sv
// Arbitrates the register-file debug port between JTAG and core
// writeback; requests a pipeline halt if JTAG is starved too long.
module jtag_reg_ctrl #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    jtag_reg_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state;
    state_t      state_nx;
    logic        we_q;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic [31:0] rdata_q;
    logic [7:0]  wait_cnt;
    logic [7:0]  cnt_nx;
    logic        halt_q;
    logic        grant;
    logic        blocked;
    logic        busy;
    logic        ack;
    logic        regs_we;

    assign grant   = (state == ARB) && !bus.ex_we_i;
    assign blocked = (state == ARB) && bus.ex_we_i;
    assign cnt_nx  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: accept in IDLE, wait for a free writeback slot in ARB.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.req_i) state_nx = ARB;
            ARB:     if (grant) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state; x0 writes are silently dropped.
    always_comb begin
        busy    = (state != IDLE);
        ack     = (state == DONE);
        regs_we = grant && we_q && (addr_q != 5'd0) && !rst;
    end

    // Request latch, read capture, starvation counter and halt request.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            addr_q   <= 5'd0;
            data_q   <= 32'd0;
            rdata_q  <= 32'd0;
            wait_cnt <= 8'd0;
            halt_q   <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_i) begin
                we_q     <= bus.req_we_i;
                addr_q   <= bus.req_addr_i;
                data_q   <= bus.req_data_i;
                wait_cnt <= 8'd0;
            end
            if (grant && !we_q) rdata_q <= bus.regs_rdata_i;
            if (blocked) wait_cnt <= cnt_nx;
            halt_q <= blocked && (cnt_nx >= LIMIT);
        end
    end

    assign bus.busy_o      = busy;
    assign bus.ack_o       = ack;
    assign bus.halt_o      = halt_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.regs_we_o   = regs_we;
    assign bus.regs_addr_o = addr_q;
    assign bus.regs_data_o = data_q;

endmodule
